// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, funct3 values and shift width.
// Used by the ALU, the main decoder and the ALU issue unit.
package alu_pkg;

    localparam int SHAMT_W = 5;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b01000,
        ALU_SLL  = 5'b00001,
        ALU_SLT  = 5'b00010,
        ALU_SLTU = 5'b00011,
        ALU_XOR  = 5'b00100,
        ALU_SRL  = 5'b00101,
        ALU_SRA  = 5'b01101,
        ALU_OR   = 5'b00110,
        ALU_AND  = 5'b00111
    } alu_op_t;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SR);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational funct3/f7b5/R-vs-I decode into ALU op, shift mask
// enable and illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_f7b5,
    input  logic       i_is_r,
    input  logic [6:0] i_imm_hi,
    output logic [4:0] o_op,
    output logic       o_shift_mask,
    output logic       o_illegal
);

    logic w_shift;
    logic w_f7sel;
    logic w_bad_r;
    logic w_bad_slli;
    logic w_bad_imm;
    logic w_imm_ok;

    assign w_shift = is_shift(i_funct3);

    // In I-type, bit 30 only chooses SRA over SRL; elsewhere it is imm
    assign w_f7sel = i_f7b5 & (i_is_r | (i_funct3 == F3_SR));

    assign w_bad_r = i_is_r & i_f7b5
                   & (i_funct3 != F3_ADD)
                   & (i_funct3 != F3_SR);

    assign w_bad_slli = !i_is_r & i_f7b5
                      & (i_funct3 == F3_SLL);

    assign w_imm_ok = (i_imm_hi == F7_BASE)
                    | (i_imm_hi == F7_ALT);

    assign w_bad_imm = !i_is_r & w_shift & !w_imm_ok;

    assign o_illegal = w_bad_r | w_bad_slli | w_bad_imm;

    assign o_shift_mask = w_shift;

    always_comb begin
        o_op = ALU_ADD;
        if (!o_illegal) begin
            o_op = {1'b0, w_f7sel, i_funct3};
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage valid/ready front end for the combinational ALU: stage X
// drives the ALU inputs, stage R returns the result and flags.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [2:0]       req_funct3,
    input  logic             req_f7b5,
    input  logic             req_is_r,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [4:0]       alu_op,
    input  logic [31:0]      alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic             r_x_valid;
    logic             r_x_illegal;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [4:0]       r_alu_op;

    logic             r_r_valid;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_illegal;

    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;

    logic             w_x_ready;
    logic             w_req_fire;
    logic             w_rsp_fire;
    logic [4:0]       w_op;
    logic             w_shift_mask;
    logic             w_illegal;
    logic [31:0]      w_b;

    alu_op_decode u_dec (
        .i_funct3     (req_funct3),
        .i_f7b5       (req_f7b5),
        .i_is_r       (req_is_r),
        .i_imm_hi     (req_b[11:5]),
        .o_op         (w_op),
        .o_shift_mask (w_shift_mask),
        .o_illegal    (w_illegal)
    );

    assign w_x_ready  = !r_r_valid | rsp_ready;
    assign req_ready  = !r_x_valid | w_x_ready;
    assign w_req_fire = req_valid & req_ready;
    assign w_rsp_fire = r_r_valid & rsp_ready;

    // The ALU shifts by the whole operand, so trim to shamt here
    assign w_b = w_shift_mask
               ? {{(32 - SHAMT_W){1'b0}}, req_b[SHAMT_W-1:0]}
               : req_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_valid   <= 1'b0;
            r_x_illegal <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
        end else if (w_req_fire) begin
            r_x_valid   <= 1'b1;
            r_x_illegal <= w_illegal;
            r_alu_a     <= w_illegal ? '0 : req_a;
            r_alu_b     <= w_illegal ? '0 : w_b;
            r_alu_op    <= w_op;
        end else if (w_x_ready) begin
            r_x_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r_valid     <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_illegal <= 1'b0;
        end else if (w_x_ready) begin
            r_r_valid <= r_x_valid;
            if (r_x_valid) begin
                r_rsp_data    <= r_x_illegal ? '0 : alu_res;
                r_rsp_illegal <= r_x_illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt   <= '0;
            r_illegal_cnt <= '0;
        end else if (w_rsp_fire) begin
            if (r_rsp_illegal) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end else begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign rsp_valid   = r_r_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_illegal = r_rsp_illegal;
    assign issue_cnt   = r_issue_cnt;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a behavioural ALU and a
// field-level reference model of decode, masking and results.
module tb_alu_issue_unit;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [2:0]       req_funct3;
    logic             req_f7b5;
    logic             req_is_r;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [4:0]       alu_op;
    logic [31:0]      alu_res;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_illegal;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] illegal_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic        ill;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t             exp_q[$];
    int               tests;
    int               fails;
    logic [CNT_W-1:0] exp_issue;
    logic [CNT_W-1:0] exp_ill;
    int               rdy_mode;

    alu_issue_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_funct3  (req_funct3),
        .req_f7b5    (req_f7b5),
        .req_is_r    (req_is_r),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_res     (alu_res),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_illegal (rsp_illegal),
        .issue_cnt   (issue_cnt),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU: shifts use the whole B operand
    always_comb begin
        alu_res = 32'hDEADBEEF;
        case (alu_op)
            5'b00000: alu_res = alu_a + alu_b;
            5'b01000: alu_res = alu_a - alu_b;
            5'b00001: alu_res = alu_a << alu_b;
            5'b00010: alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
            5'b00011: alu_res = {31'b0, alu_a < alu_b};
            5'b00100: alu_res = alu_a ^ alu_b;
            5'b00101: alu_res = alu_a >> alu_b;
            5'b01101: alu_res = 32'($signed(alu_a) >>> alu_b);
            5'b00110: alu_res = alu_a | alu_b;
            5'b00111: alu_res = alu_a & alu_b;
            default:  alu_res = 32'hDEADBEEF;
        endcase
    end

    function automatic exp_t ref_model(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [2:0]  f3,
                                       input logic        f7,
                                       input logic        isr);
        exp_t       e;
        logic       sh_op;
        logic [4:0] sh;
        sh_op = (f3 == 3'd1) || (f3 == 3'd5);
        sh    = b[4:0];
        e     = '0;
        if (isr)
            e.ill = f7 && (f3 != 3'd0) && (f3 != 3'd5);
        else
            e.ill = (sh_op && b[11:5] != 7'h00 && b[11:5] != 7'h20)
                 || (f3 == 3'd1 && f7);
        if (e.ill) return e;
        e.a = a;
        e.b = sh_op ? {27'b0, sh} : b;
        case (f3)
            3'd0: if (isr && f7) begin
                      e.data = a - b; e.op = 5'b01000;
                  end else begin
                      e.data = a + b; e.op = 5'b00000;
                  end
            3'd1: begin e.data = a << sh; e.op = 5'b00001; end
            3'd2: begin
                      e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                      e.op = 5'b00010;
                  end
            3'd3: begin e.data = (a < b) ? 32'd1 : 32'd0; e.op = 5'b00011; end
            3'd4: begin e.data = a ^ b; e.op = 5'b00100; end
            3'd5: if (f7) begin
                      e.data = 32'($signed(a) >>> sh); e.op = 5'b01101;
                  end else begin
                      e.data = a >> sh; e.op = 5'b00101;
                  end
            3'd6: begin e.data = a | b; e.op = 5'b00110; end
            default: begin e.data = a & b; e.op = 5'b00111; end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: sampled mid-cycle; a handshake seen here fires next edge
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            chk("issue_cnt", {16'b0, issue_cnt}, {16'b0, exp_issue});
            chk("illegal_cnt", {16'b0, illegal_cnt}, {16'b0, exp_ill});
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got data %h, none expected",
                             rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, e.ill});
                    if (e.ill) exp_ill++;
                    else exp_issue++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic f7,
                        input logic isr);
        exp_t e;
        int   n;
        @(negedge clk);
        req_a      = a;
        req_b      = b;
        req_funct3 = f3;
        req_f7b5   = f7;
        req_is_r   = isr;
        req_valid  = 1'b1;
        #2;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got req_ready 0 expected 1");
            req_valid = 1'b0;
            return;
        end
        e = ref_model(a, b, f3, f7, isr);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("alu_op", {27'b0, alu_op}, {27'b0, e.op});
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     exp_q.size());
        end
        @(negedge clk);
        #3;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rf3;
        tests      = 0;
        fails      = 0;
        exp_issue  = '0;
        exp_ill    = '0;
        rdy_mode   = 0;
        rst        = 1'b1;
        rsp_ready  = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_funct3 = '0;
        req_f7b5   = 1'b0;
        req_is_r   = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {27'b0, alu_op}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_illegal", {31'b0, rsp_illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        send(32'd5, 32'd7, 3'b000, 1'b1, 1'b1);
        drain();
        chk("sub_issue_cnt", {16'b0, issue_cnt}, 32'd1);
        send(32'h500, 32'hFFFFFC00, 3'b000, 1'b1, 1'b0);
        send(32'h80000000, 32'h0000041F, 3'b101, 1'b1, 1'b0);
        send(32'h80000000, 32'h00000021, 3'b101, 1'b0, 1'b1);
        send(32'h12345678, 32'h9ABCDEF0, 3'b100, 1'b1, 1'b1);
        drain();
        chk("dir_issue_cnt", {16'b0, issue_cnt}, 32'd4);
        chk("dir_illegal_cnt", {16'b0, illegal_cnt}, 32'd1);

        rdy_mode = 2;
        send(32'd100, 32'd23, 3'b000, 1'b0, 1'b1);
        send(32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        chk("bp_full_ready", {31'b0, req_ready}, 32'd0);
        chk("bp_full_valid", {31'b0, rsp_valid}, 32'd1);
        fork
            begin
                send(32'hAAAA0000, 32'h0000FFFF, 3'b110, 1'b0, 1'b0);
                send(32'hFFFF00FF, 32'h00FFFF00, 3'b111, 1'b0, 1'b1);
            end
            begin
                repeat (2) begin
                    @(negedge clk);
                    #2;
                    chk("bp_stall_ready", {31'b0, req_ready}, 32'd0);
                end
                @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();
        chk("bp_issue_cnt", {16'b0, issue_cnt}, 32'd8);

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rf3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       rb[11:5] = 7'h00;
                1:       rb[11:5] = 7'h20;
                default: rb[11:5] = rb[11:5];
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
            send(ra, rb, rf3, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        rdy_mode = 2;
        send(32'd1, 32'd2, 3'b000, 1'b0, 1'b1);
        send(32'd3, 32'd4, 3'b000, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        chk("pre_rst_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_issue = '0;
        exp_ill   = '0;
        #2;
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_issue", {16'b0, issue_cnt}, 32'd0);
        chk("mid_rst_illegal", {16'b0, illegal_cnt}, 32'd0);
        rdy_mode = 0;
        repeat (10) @(negedge clk);
        #3;
        chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
